// File: rtl/mandel_scheduler.sv
// mandel_scheduler: scans a W_PIX x H_PIX grid, loads c into the iterator, counts
// iterations to divergence or MAX_ITER, and streams one result per pixel.
module mandel_scheduler #(
  parameter int WIDTH    = 32,
  parameter int W_PIX    = 4,
  parameter int H_PIX    = 4,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8,
  parameter int XW       = 8,
  parameter int YW       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  x0,
  input  logic [WIDTH-1:0]  y0,
  input  logic [WIDTH-1:0]  dx,
  input  logic [WIDTH-1:0]  dy,
  output logic [WIDTH-1:0]  c_re,
  output logic [WIDTH-1:0]  c_im,
  output logic              ld,
  input  logic              diverged,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic [ITER_W-1:0] pix_iter,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, EMIT} state_t;
  state_t            state_q;
  logic [WIDTH-1:0]  x0_q, dx_q, dy_q, c_re_q, c_im_q;
  logic [ITER_W-1:0] cnt_q, pix_iter_q;
  logic [XW-1:0]     pix_x_q;
  logic [YW-1:0]     pix_y_q;
  logic              ld_q, valid_q, busy_q, done_q;
  logic              last_x, last_y;
  assign last_x = pix_x_q == XW'(W_PIX - 1);
  assign last_y = pix_y_q == YW'(H_PIX - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      x0_q       <= '0;
      dx_q       <= '0;
      dy_q       <= '0;
      c_re_q     <= '0;
      c_im_q     <= '0;
      cnt_q      <= '0;
      pix_iter_q <= '0;
      pix_x_q    <= '0;
      pix_y_q    <= '0;
      ld_q       <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      ld_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          x0_q    <= x0;
          dx_q    <= dx;
          dy_q    <= dy;
          c_re_q  <= x0;
          c_im_q  <= y0;
          pix_x_q <= '0;
          pix_y_q <= '0;
          ld_q    <= 1'b1;
          busy_q  <= 1'b1;
          state_q <= LOAD;
        end
        LOAD: begin
          cnt_q   <= '0;
          state_q <= ITER;
        end
        // On the cap the counter already equals MAX_ITER, so both exits report cnt_q.
        ITER: if (diverged || cnt_q == ITER_W'(MAX_ITER)) begin
          pix_iter_q <= cnt_q;
          valid_q    <= 1'b1;
          state_q    <= EMIT;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
        EMIT: if (pix_ready) begin
          valid_q <= 1'b0;
          if (last_x && last_y) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            ld_q    <= 1'b1;
            state_q <= LOAD;
            pix_x_q <= last_x ? '0 : pix_x_q + 1'b1;
            pix_y_q <= last_x ? pix_y_q + 1'b1 : pix_y_q;
            c_re_q  <= last_x ? x0_q : c_re_q + dx_q;
            c_im_q  <= last_x ? c_im_q + dy_q : c_im_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign c_re      = c_re_q;
  assign c_im      = c_im_q;
  assign ld        = ld_q;
  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_iter  = pix_iter_q;
  assign pix_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_mandel_scheduler.sv
// tb_mandel_scheduler: table-driven and randomized frames checked against a
// pixel-level model of scan order, c stepping, iteration count and latency.
module tb_mandel_scheduler;
  localparam int W = 3;
  localparam int H = 2;
  localparam int M = 5;
  logic        clk = 0, rst = 1, start = 0, diverged = 0, pix_ready = 0;
  logic [31:0] x0 = 0, y0 = 0, dx = 0, dy = 0;
  logic [31:0] c_re, c_im;
  logic        ld, pix_valid, busy, done;
  logic [7:0]  pix_x, pix_y, pix_iter;
  int          checks = 0, errors = 0;

  typedef struct {
    int k;
    int stall;
    int exp_iter;
    int exp_lat;
  } vec_t;
  vec_t tbl[6];

  mandel_scheduler #(.WIDTH(32), .W_PIX(W), .H_PIX(H), .MAX_ITER(M), .ITER_W(8), .XW(8), .YW(8)) dut (
    .clk(clk), .rst(rst), .start(start), .x0(x0), .y0(y0), .dx(dx), .dy(dy),
    .c_re(c_re), .c_im(c_im), .ld(ld), .diverged(diverged),
    .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_pixel(input int col, input int row, input int k, input int stall,
                          input int exp_iter, input int exp_lat,
                          input logic [31:0] fx0, input logic [31:0] fy0,
                          input logic [31:0] fdx, input logic [31:0] fdy, input bit poke);
    int n = 0;
    int lat = 0;
    int j = 0;
    logic [31:0] ere, eim;
    bit last;
    ere = fx0 + fdx * 32'(col);
    eim = fy0 + fdy * 32'(row);
    last = (col == W - 1) && (row == H - 1);
    while (!ld && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ld_seen", 64'(ld), 64'd1);
    if (!ld) return;
    chk("c_re", 64'(c_re), 64'(ere));
    chk("c_im", 64'(c_im), 64'(eim));
    chk("busy_load", 64'(busy), 64'd1);
    diverged = 0;
    while (lat < 300) begin
      @(negedge clk);
      lat++;
      if (pix_valid) break;
      diverged = (j == k);
      j++;
    end
    diverged = 0;
    chk("pix_valid", 64'(pix_valid), 64'd1);
    chk("pix_x", 64'(pix_x), 64'(col));
    chk("pix_y", 64'(pix_y), 64'(row));
    chk("pix_iter", 64'(pix_iter), 64'(exp_iter));
    chk("latency", 64'(lat), 64'(exp_lat));
    for (int s = 0; s < stall; s++) begin
      if (poke && s == 0) begin
        start = 1;
        x0 = 32'hDEAD_BEEF;
        y0 = 32'h1234_5678;
      end
      @(negedge clk);
      start = 0;
      chk("stall_hold", {pix_valid, ld, done, pix_x, pix_y, pix_iter, c_re},
          {1'b1, 1'b0, 1'b0, 8'(col), 8'(row), 8'(exp_iter), ere});
    end
    pix_ready = 1;
    @(negedge clk);
    pix_ready = 0;
    chk("valid_drop", 64'(pix_valid), 64'd0);
    chk("done", 64'(done), 64'(last));
    if (last) chk("busy_end", 64'(busy), 64'd0);
    else chk("next_ld", 64'(ld), 64'd1);
  endtask

  task automatic run_frame(input logic [31:0] fx0, input logic [31:0] fy0,
                           input logic [31:0] fdx, input logic [31:0] fdy,
                           input bit use_tbl, input bit poke);
    int idx = 0;
    @(negedge clk);
    x0 = fx0; y0 = fy0; dx = fdx; dy = fdy;
    start = 1;
    @(negedge clk);
    start = 0;
    x0 = $urandom; y0 = $urandom; dx = $urandom; dy = $urandom;
    chk("ld_after_start", 64'(ld), 64'd1);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (use_tbl) begin
          do_pixel(c, r, tbl[idx].k, tbl[idx].stall, tbl[idx].exp_iter, tbl[idx].exp_lat,
                   fx0, fy0, fdx, fdy, poke && idx == 2);
        end else begin
          int k, ei;
          k  = int'($urandom_range(0, M + 2));
          ei = (k < M) ? k : M;
          do_pixel(c, r, k, int'($urandom_range(0, 2)), ei, ei + 2, fx0, fy0, fdx, fdy, 1'b0);
        end
        idx++;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("idle_no_ld", {busy, ld}, 2'b00);
  endtask

  initial begin
    tbl[0] = '{0, 0, 0, 2};
    tbl[1] = '{3, 1, 3, 5};
    tbl[2] = '{5, 2, 5, 7};
    tbl[3] = '{9, 0, 5, 7};
    tbl[4] = '{4, 3, 4, 6};
    tbl[5] = '{1, 10, 1, 3};
    #12;
    chk("reset_outputs", {c_re, c_im, ld, pix_valid, busy, done, pix_x, pix_y, pix_iter}, '0);
    @(negedge clk);
    rst = 0;
    run_frame(32'h1000_0000, 32'hFF00_0000, 32'h0040_0000, 32'h0080_0000, 1'b1, 1'b1);
    @(negedge clk);
    x0 = $urandom; y0 = $urandom; dx = $urandom; dy = $urandom;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("async_reset", {c_re, c_im, ld, pix_valid, busy, done, pix_x, pix_y, pix_iter}, '0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_reset_idle", {busy, ld, pix_valid}, 3'b000);
    end
    run_frame(32'h0000_0000, 32'h0000_0000, 32'hFFF0_0000, 32'hFFE0_0000, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) run_frame($urandom, $urandom, $urandom, $urandom, 1'b0, 1'b0);
    run_frame(32'hFFFF_FFF0, 32'h7FFF_FFF0, 32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
